// File: rtl/prim_arbiter_wrr_if.sv
// Bundle of requester-side and downstream-side signals of the weighted
// round-robin arbiter. master = arbiter view, slave = environment view.
// Field names follow the arbiter's datasheet names so the bench reads 1:1.
interface prim_arbiter_wrr_if #(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int WW = 4
);
  localparam int IW = $clog2(N);

  // requester side
  logic [N-1:0]    req_i;
  logic [N*DW-1:0] data_i;
  logic [N*WW-1:0] cfg_weight_i;
  logic [N-1:0]    gnt_o;

  // downstream channel
  logic [IW-1:0]   idx_o;
  logic            valid_o;
  logic [DW-1:0]   data_o;
  logic            ready_i;

  modport master (
    input  req_i,
    input  data_i,
    input  cfg_weight_i,
    input  ready_i,
    output gnt_o,
    output idx_o,
    output valid_o,
    output data_o
  );

  modport slave (
    output req_i,
    output data_i,
    output cfg_weight_i,
    output ready_i,
    input  gnt_o,
    input  idx_o,
    input  valid_o,
    input  data_o
  );
endinterface

// File: rtl/prim_arbiter_wrr.sv
// Weighted round-robin arbiter: N requesters share one ready/valid channel.
// Latency: zero cycles (request to valid_o/data_o is combinational).
// Backpressure: a stalled selection is locked until accepted or dropped.
module prim_arbiter_wrr #(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int WW = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  prim_arbiter_wrr_if.master bus
);
  localparam int IW = $clog2(N);

  // Burst owner, grants already given in its burst, and the lock that pins
  // the selection while downstream stalls.
  logic [IW-1:0] cur_q;
  logic [WW-1:0] cnt_q;
  logic          lock_q;
  logic [IW-1:0] lidx_q;
  logic          lfresh_q;

  logic [WW-1:0] weight [N];
  logic [DW-1:0] word   [N];
  logic [N-1:0]  elig;

  for (genvar k = 0; k < N; k++) begin : g_unpack
    assign weight[k] = bus.cfg_weight_i[k*WW +: WW];
    assign word[k]   = bus.data_i[k*DW +: DW];
    assign elig[k]   = bus.req_i[k] && (weight[k] != '0);
  end

  // cnt_q == 0 only happens straight out of reset and means "no burst in
  // progress", so the very first selection searches from index 0 instead of
  // continuing a phantom burst on the reset owner N-1.
  logic cont;
  assign cont = elig[cur_q] && (cnt_q != '0) && (cnt_q < weight[cur_q]);

  logic          hit;
  logic [IW-1:0] srch_idx;
  logic [IW-1:0] scan;

  // Rotating search: cur_q+1 .. N-1, 0 .. cur_q, first eligible wins.
  always_comb begin
    hit      = 1'b0;
    srch_idx = '0;
    scan     = cur_q;
    for (int i = 0; i < N; i++) begin
      scan = (scan == IW'(N-1)) ? '0 : scan + IW'(1);
      if (!hit && elig[scan]) begin
        hit      = 1'b1;
        srch_idx = scan;
      end
    end
  end

  logic [IW-1:0] sel;
  logic          fresh;
  logic          valid;

  // Selection: a lock wins over everything (weight ignored), then the
  // running burst, then a fresh search result.
  always_comb begin
    sel   = '0;
    fresh = 1'b0;
    valid = 1'b0;
    if (lock_q) begin
      sel   = lidx_q;
      fresh = lfresh_q;
      valid = bus.req_i[lidx_q];
    end else if (cont) begin
      sel   = cur_q;
      valid = 1'b1;
    end else if (hit) begin
      sel   = srch_idx;
      fresh = 1'b1;
      valid = 1'b1;
    end
  end

  logic handshake;
  assign handshake   = valid && bus.ready_i;

  assign bus.valid_o = valid;
  assign bus.idx_o   = valid ? sel : '0;
  assign bus.data_o  = valid ? word[sel] : '0;

  // One-hot grant; ready_i only feeds this path.
  always_comb begin
    bus.gnt_o = '0;
    for (int k = 0; k < N; k++) begin
      if (handshake && (sel == IW'(k))) bus.gnt_o[k] = 1'b1;
    end
  end

  // Burst bookkeeping and stall lock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cur_q    <= IW'(N-1);
      cnt_q    <= '0;
      lock_q   <= 1'b0;
      lidx_q   <= '0;
      lfresh_q <= 1'b0;
    end else if (lock_q && !valid) begin
      // locked requester withdrew: release without touching the burst
      lock_q <= 1'b0;
    end else if (handshake) begin
      lock_q <= 1'b0;
      if (fresh) begin
        cur_q <= sel;
        cnt_q <= WW'(1);
      end else if (cnt_q != '1) begin
        cnt_q <= cnt_q + WW'(1);
      end
    end else if (valid) begin
      // stalled: pin selection and remember whether it starts a new burst
      lock_q   <= 1'b1;
      lidx_q   <= sel;
      lfresh_q <= fresh;
    end
  end
endmodule

// File: tb/tb_prim_arbiter_wrr.sv
// Directed bench for prim_arbiter_wrr with hand-computed expectations.
module tb_prim_arbiter_wrr;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int WW = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  prim_arbiter_wrr_if #(.N(N), .DW(DW), .WW(WW)) bus ();

  prim_arbiter_wrr #(.N(N), .DW(DW), .WW(WW)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(input logic [3:0] w0, input logic [3:0] w1,
                       input logic [3:0] w2, input logic [3:0] w3);
    bus.cfg_weight_i = {w3, w2, w1, w0};
  endtask

  int exp_rr [6]  = '{0, 1, 2, 3, 0, 1};
  int exp_w  [10] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
  int exp_ar [3]  = '{0, 0, 1};

  initial begin
    rst_n        = 1'b0;
    bus.req_i    = '0;
    bus.ready_i  = 1'b1;
    bus.data_i   = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
    set_w(1, 1, 1, 1);

    // reset / idle
    #1;
    check("rst_valid", 32'(bus.valid_o), 32'd0);
    check("rst_gnt",   32'(bus.gnt_o),   32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("idle_valid", 32'(bus.valid_o), 32'd0);
      check("idle_gnt",   32'(bus.gnt_o),   32'd0);
      check("idle_idx",   32'(bus.idx_o),   32'd0);
      check("idle_data",  bus.data_o,       32'd0);
      tick();
    end

    // plain round robin
    bus.req_i = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("rr_idx", 32'(bus.idx_o), 32'(exp_rr[i]));
      check("rr_gnt", 32'(bus.gnt_o), 32'd1 << exp_rr[i]);
      tick();
    end

    // weighted: w0=3, w1=1
    set_w(3, 1, 1, 1);
    bus.req_i = 4'b0011;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("w_idx", 32'(bus.idx_o), 32'(exp_w[i]));
      tick();
    end
    bus.req_i = 4'b0010;
    #1;
    check("w_drop_idx",   32'(bus.idx_o),   32'd1);
    check("w_drop_valid", 32'(bus.valid_o), 32'd1);
    tick();

    // backpressure lock on requester 2
    set_w(1, 1, 1, 1);
    bus.req_i   = 4'b1111;
    bus.ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_idx",  32'(bus.idx_o), 32'd2);
      check("bp_data", bus.data_o,     32'hCAFE_0002);
      check("bp_gnt",  32'(bus.gnt_o), 32'd0);
      tick();
    end
    bus.ready_i = 1'b1;
    #1;
    check("bp_rel_gnt", 32'(bus.gnt_o), 32'b0100);
    tick();
    #1;
    check("bp_next_idx", 32'(bus.idx_o), 32'd3);
    tick();

    // weight 0 masks a requester
    set_w(1, 1, 0, 1);
    bus.req_i = 4'b0100;
    #1;
    check("mask_valid", 32'(bus.valid_o), 32'd0);
    check("mask_gnt",   32'(bus.gnt_o),   32'd0);
    tick();
    set_w(1, 1, 1, 1);

    // drop while locked on requester 1
    bus.req_i   = 4'b1010;
    bus.ready_i = 1'b0;
    #1;
    check("dl_idx", 32'(bus.idx_o), 32'd1);
    tick();
    bus.req_i   = 4'b1000;
    bus.ready_i = 1'b1;
    #1;
    check("dl_valid", 32'(bus.valid_o), 32'd0);
    check("dl_gnt",   32'(bus.gnt_o),   32'd0);
    tick();
    #1;
    check("dl_next_valid", 32'(bus.valid_o), 32'd1);
    check("dl_next_idx",   32'(bus.idx_o),   32'd3);
    check("dl_next_gnt",   32'(bus.gnt_o),   32'b1000);
    tick();

    // async reset in the middle of a burst of requester 0
    set_w(3, 1, 1, 1);
    bus.req_i = 4'b0011;
    #1;
    check("ar_first_idx", 32'(bus.idx_o), 32'd0);
    tick();
    #1;
    check("ar_cont_idx", 32'(bus.idx_o), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_in_rst_valid", 32'(bus.valid_o), 32'd1);
    check("ar_in_rst_idx",   32'(bus.idx_o),   32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ar_post_idx", 32'(bus.idx_o), 32'(exp_ar[i]));
      tick();
    end

    // maximum weight: burst of exactly 15 grants
    set_w(15, 1, 1, 1);
    for (int i = 0; i < 15; i++) begin
      #1;
      check("wmax_idx", 32'(bus.idx_o), 32'd0);
      tick();
    end
    #1;
    check("wmax_end_idx", 32'(bus.idx_o), 32'd1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
